// File: rtl/serial_sub_nor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first through a 1-bit slice.
// start is accepted only in IDLE; done pulses for one cycle WIDTH edges after the accepting edge.
module serial_sub_nor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_nxt;
  logic             last;
  logic [WIDTH-1:0] sd_nxt;

  // single full-subtractor slice
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign sd_nxt = {d, sd[WIDTH-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // diff/bout are only touched on the DONE-entry edge so they hold the previous result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
            sd  <= '0;
          end
        end
        RUN: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          sd  <= sd_nxt;
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= sd_nxt;
            bout <= br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_nor.sv
// Bench for serial_sub_nor: WIDTH=8 and WIDTH=4 instances checked every cycle against a transaction-level model.
module tb_serial_sub_nor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       st[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       bi[2];

  logic       bs8, dn8, bo8;
  logic [7:0] d8;
  logic       bs4, dn4, bo4;
  logic [3:0] d4;

  int n_cmp = 0;
  int n_mis = 0;

  // model: active flag, cycles since accept, pending and visible results
  bit m_act[2];
  int m_t[2];
  int m_pd[2];
  int m_pb[2];
  int m_diff[2];
  int m_bout[2];

  always #5 clk = ~clk;

  serial_sub_nor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st[0]), .a(av[0]), .b(bv[0]), .bin(bi[0]),
    .busy(bs8), .done(dn8), .diff(d8), .bout(bo8)
  );

  serial_sub_nor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st[1]), .a(av[1][3:0]), .b(bv[1][3:0]), .bin(bi[1]),
    .busy(bs4), .done(dn4), .diff(d4), .bout(bo4)
  );

  function automatic int wd(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int msk(input int i);
    return (1 << wd(i)) - 1;
  endfunction

  function automatic bit dn_of(input int i);
    return (i == 0) ? dn8 : dn4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]  <= 1'b0;
        m_t[i]    <= 0;
        m_diff[i] <= 0;
        m_bout[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (st[i] === 1'b1) begin
            m_act[i] <= 1'b1;
            m_t[i]   <= 0;
            m_pd[i]  <= ((int'(av[i]) & msk(i)) - (int'(bv[i]) & msk(i)) - int'(bi[i])) & msk(i);
            m_pb[i]  <= ((int'(av[i]) & msk(i)) < (int'(bv[i]) & msk(i)) + int'(bi[i])) ? 1 : 0;
          end
        end else begin
          m_t[i] <= m_t[i] + 1;
          if (m_t[i] + 1 == wd(i)) begin
            m_diff[i] <= m_pd[i];
            m_bout[i] <= m_pb[i];
          end
          if (m_t[i] + 1 == wd(i) + 1) m_act[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy8", 32'(bs8), 32'(m_act[0]));
    chk("done8", 32'(dn8), 32'(m_act[0] && m_t[0] == 8));
    chk("diff8", 32'(d8), m_diff[0]);
    chk("bout8", 32'(bo8), m_bout[0]);
    chk("busy4", 32'(bs4), 32'(m_act[1]));
    chk("done4", 32'(dn4), 32'(m_act[1] && m_t[1] == 4));
    chk("diff4", 32'(d4), m_diff[1]);
    chk("bout4", 32'(bo4), m_bout[1]);
  end

  task automatic run_op(input int i, input int x, input int y, input int c, input bit scr);
    int k;
    @(negedge clk);
    st[i] = 1'b1;
    av[i] = 8'(x);
    bv[i] = 8'(y);
    bi[i] = c[0];
    @(negedge clk);
    st[i] = 1'b0;
    k = 0;
    while (!dn_of(i) && k < wd(i) + 4) begin
      if (scr) begin
        av[i] = 8'($urandom);
        bv[i] = 8'($urandom);
        bi[i] = 1'($urandom);
        st[i] = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    chk("latency", k, wd(i));
  endtask

  initial begin
    int pulses;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0; bi[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bs8), 0);
    chk("rst_done", 32'(dn8), 0);
    chk("rst_diff", 32'(d8), 0);
    chk("rst_bout", 32'(bo8), 0);
    rst = 1'b0;

    run_op(0, 8'h05, 8'h03, 0, 1'b0);
    chk("r1_busy", 32'(bs8), 1);
    chk("r1_diff", 32'(d8), 32'h02);
    chk("r1_bout", 32'(bo8), 0);
    run_op(0, 8'h03, 8'h05, 0, 1'b0);
    chk("r2_diff", 32'(d8), 32'hFE);
    chk("r2_bout", 32'(bo8), 1);
    run_op(0, 8'h00, 8'h00, 1, 1'b0);
    chk("r3_diff", 32'(d8), 32'hFF);
    chk("r3_bout", 32'(bo8), 1);
    run_op(0, 8'hFF, 8'h00, 1, 1'b0);
    chk("r4_diff", 32'(d8), 32'hFE);
    chk("r4_bout", 32'(bo8), 0);

    // start held high; operands scrambled whenever the next edge cannot accept
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h10; bv[0] = 8'h01; bi[0] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dn8) begin
        pulses++;
        chk("held_diff", 32'(d8), 32'h0F);
      end
      if (!m_act[0]) begin
        av[0] = 8'h10; bv[0] = 8'h01; bi[0] = 1'b0;
      end else begin
        av[0] = 8'($urandom); bv[0] = 8'($urandom); bi[0] = 1'($urandom);
      end
    end
    st[0] = 1'b0;
    chk("held_pulses", pulses, 4);

    // asynchronous reset in the middle of bit 4
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'h37; bv[0] = 8'h12; bi[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bs8), 0);
    chk("arst_done", 32'(dn8), 0);
    chk("arst_diff", 32'(d8), 0);
    chk("arst_bout", 32'(bo8), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(dn8), 0);
    end
    run_op(0, 8'h37, 8'h12, 0, 1'b0);
    chk("post_rst_diff", 32'(d8), 32'h25);
    chk("post_rst_bout", 32'(bo8), 0);

    for (int n = 0; n < 150; n++) begin
      run_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), 1'b1);
    end
    st[0] = 1'b0;

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(1, x, y, c, 1'b0);
          $display("t=%0t a=%0d b=%0d bin=%0d diff=%0d bout=%0d", $time, x, y, c, d4, bo4);
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/serial_sub_nor.md
Name: serial_sub_nor

Overview:
- Bit-serial N-bit subtractor. Computes diff = a - b - bin one bit per clock, LSB first, through a single 1-bit full-subtractor slice and a registered borrow flop.
- Pairs with the parallel full-adder datapath as its arithmetic inverse.
- Sits behind a start/busy/done handshake, so a controller can issue one subtraction and collect the result.
- Trades area for latency compared with a ripple subtractor.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result is valid while it is high.
- diff  output  WIDTH  result register.
- bout  output  1  final borrow-out register.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; internal shift registers, borrow flop and bit counter cleared.
  - busy=0, done=0, diff=0, bout=0.
  - An operation in flight is aborted and no done pulse is produced.
  - Deassertion takes effect on the first clk edge with rst=0.
- State IDLE:
  - start=1 at an edge: capture a, b, bin into sa, sb, br; clear counter and the internal diff shift register; go to RUN.
  - start=0: stay in IDLE.
- State RUN, one bit per edge:
  - d = sa[0] ^ sb[0] ^ br.
  - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - d shifts into the internal diff register at the MSB; sa and sb shift right; counter increments.
  - On the edge where counter == WIDTH-1 (the WIDTH-th bit):
    - load diff from the completed shift register including this bit;
    - bout = br_next;
    - go to DONE.
- State DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency:
  - start accepted at edge 0; done high from edge WIDTH to edge WIDTH+1.
  - Earliest next accepted start is edge WIDTH+2, so the back-to-back period is WIDTH+2 cycles.
- Output stability:
  - diff and bout change only on the DONE-entry edge; they hold the previous result throughout RUN and IDLE.
  - done is asserted only in DONE.
- Input rules:
  - start is ignored while busy=1, including the DONE cycle.
  - a, b and bin may change freely after the accepting edge without affecting the result.
- Arithmetic: modulo 2^WIDTH. bout=1 exactly when a < b + bin as unsigned values.
- Counter width is clog2(WIDTH), rounded up so that it can hold WIDTH-1.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start pulse at edge 0 -> done=1 only in the cycle after edge 8; diff=0x02, bout=0; busy=1 for edges 1..8 inclusive.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- start held high with a=0x10, b=0x01 -> one done pulse every 10 cycles with diff=0x0F each time. Changing a/b during RUN does not alter the pending result.
- rst asserted asynchronously mid-clock at bit 4 of a run -> busy, done, diff and bout go to 0 immediately with no clock edge; no done pulse follows; a fresh start after release gives a correct result.
- WIDTH=4, exhaustive sweep over all a, b in 0..15 and bin in {0,1} -> diff == (a-b-bin) mod 16 and bout == (a < b+bin), each checked against a reference model; print time, a, b, bin, diff, bout per case.
